// File: rtl/mem_arb_pkg.sv
// Shared widths, request record and id-width helper for the memory port arbiter.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    // A single requester still needs a one-bit id so the id registers have a width.
    function automatic int req_id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from rr_ptr,
// pointer advances past the winner only when a grant is issued.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   valid_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] win_o,
    output logic           accept_o
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           found;
    int             idx;

    always_comb begin
        grant_o = '0;
        win_o   = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && valid_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                win_o        = IDW'(idx);
            end
        end
        accept_o = found;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_o)
            ptr_d = (int'(win_o) == N - 1) ? '0 : win_o + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port among NUM_REQ slots: grant, issue
// register onto the memory port, then a response pulse one cycle later.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_data_in,
    output logic                      mem_write_en,
    input  logic [DATA_W-1:0]         mem_data_out
);

    localparam int IDW = req_id_w(NUM_REQ);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } iss_t;

    logic [IDW-1:0] win;
    logic           accept;
    iss_t           sel_d, iss_q;
    logic           iss_valid_q, rsp_valid_q;
    logic [IDW-1:0] iss_id_q, rsp_id_q;

    rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (req_valid),
        .grant_o  (req_ready),
        .win_o    (win),
        .accept_o (accept)
    );

    always_comb begin
        sel_d.we    = req_we[win];
        sel_d.addr  = req_addr[int'(win)*ADDR_W +: ADDR_W];
        sel_d.wdata = req_wdata[int'(win)*DATA_W +: DATA_W];
    end

    // Async reset also drops a store sitting in the issue stage before it reaches memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
            iss_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            iss_valid_q <= accept;
            if (accept) begin
                iss_q    <= sel_d;
                iss_id_q <= win;
            end
            rsp_valid_q <= iss_valid_q;
            rsp_id_q    <= iss_id_q;
        end
    end

    assign mem_addr     = iss_q.addr;
    assign mem_data_in  = iss_q.wdata;
    assign mem_write_en = iss_valid_q & iss_q.we;
    assign rsp_rdata    = mem_data_out;

    always_comb begin
        rsp_valid = '0;
        if (rsp_valid_q) rsp_valid[rsp_id_q] = 1'b1;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the single-port, synchronous-read `main_memory` (256 x 8, one-cycle registered read) among `NUM_REQ` VLIW load/store slots. It accepts one request per cycle over a valid/ready handshake. It registers the winner onto the memory port and returns a per-requester response pulse with read data two cycles after acceptance. It sits between the slot load/store units and the `main_memory` instance.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `ADDR_W`, 8: memory address width.
- `DATA_W`, 8: memory data width.
- `clk` input 1: the one clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `req_valid` input NUM_REQ: request pending, one bit per requester.
- `req_we` input NUM_REQ: 1 = store, 0 = load.
- `req_addr` input NUM_REQ*ADDR_W: packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- `req_wdata` input NUM_REQ*DATA_W: packed store data, same packing.
- `req_ready` output NUM_REQ: one-hot-or-zero grant; handshake completes when valid & ready.
- `rsp_valid` output NUM_REQ: one-cycle completion pulse to the originating requester.
- `rsp_rdata` output DATA_W: shared response data, meaningful only where rsp_valid is set.
- `mem_addr` output ADDR_W: to memory `addr`.
- `mem_data_in` output DATA_W: to memory `data_in`.
- `mem_write_en` output 1: to memory `write_en`.
- `mem_data_out` input DATA_W: from memory `data_out`.

## Operation
- Grant is combinational each cycle.
  - Search `req_valid` starting at `rr_ptr` and wrapping modulo NUM_REQ.
  - The first set bit wins, and `req_ready` is asserted for that requester only.
  - No valid requests: `req_ready` = 0.
- `rr_ptr` updates only on an accepted handshake, to (winner+1) mod NUM_REQ. It holds otherwise.
- Requester rules:
  - Hold `req_valid`, `req_we`, `req_addr` and `req_wdata` stable until accepted.
  - `req_valid` must not depend on `req_ready`.
- Issue stage (registered): on acceptance, capture addr, wdata, we and the winner index; set `iss_valid`.
  - `mem_write_en` = `iss_valid & iss_we`.
  - `mem_addr` and `mem_data_in` hold their last value when idle.
- Response stage (registered): `rsp_valid_q` and `rsp_id` are delayed one cycle from the issue stage.
  - `rsp_valid[rsp_id]` = `rsp_valid_q`.
  - `rsp_rdata` = `mem_data_out` passed through.
- Stores also produce a response pulse (write acknowledge). Their `rsp_rdata` is the pre-write contents, since memory reads old data on write.
- Memory order equals grant order. A load granted the cycle after a store to the same address returns the stored value.
- Starvation bound: a continuously valid requester is granted within NUM_REQ cycles.

## Timing
- Reset values:
  - `rr_ptr` = 0
  - `iss_valid` = 0, `rsp_valid_q` = 0
  - `mem_write_en` = 0, `mem_addr` = 0, `mem_data_in` = 0
  - `rsp_valid` = 0
  - `req_ready` is combinational and may assert during reset; handshakes while `rst` is high are discarded.
- Latency: accepted in cycle N → memory port driven in N+1 (sampled at the end of N+1) → `rsp_valid` high in N+2.
- Throughput: one request per cycle, with no bubbles between back-to-back grants.
- Reset mid-operation: in-flight issue/response entries are dropped with no `rsp_valid`. A store in the issue stage is not written if `rst` rises before its clock edge.
- Simultaneous valids: exactly one grant per cycle. Losers keep `req_valid` high and win in later cycles by rotation.
- Pointer wrap: winner NUM_REQ-1 → `rr_ptr` = 0.

## Structure
- Package `mem_arb_pkg`:
  - `MEM_ADDR_W` = 8, `MEM_DATA_W` = 8.
  - `mem_req_t` struct {we, addr, wdata}.
  - `REQ_ID_W` = $clog2(NUM_REQ) helper function.
- Sub-module `rr_arbiter` (parameter N): contains the combinational one-hot grant and the `rr_ptr` register with advance-on-accept.
- Top-level holds the issue and response pipeline registers and the port muxing.

## Test plan
- Single load: memory preloaded [0x10]=0xA5; requester 2 loads 0x10 in cycle 0 → `req_ready[2]` in cycle 0; `rsp_valid` = 4'b0100 with `rsp_rdata` = 0xA5 in cycle 2.
- All four valid continuously, from reset → grants 0,1,2,3,0,… one per cycle; `rsp_valid` follows the same sequence two cycles later.
- Store/load hazard: req 1 stores 0x3C to 0x20, then req 2 loads 0x20 the next cycle → req 2 receives 0x3C; req 1 ack returns old contents.
- Fairness: req 0 always valid, req 3 raises valid at cycle 5 → req 3 is granted by cycle 5+4 at the latest; no requester waits more than 4 cycles.
- Reset mid-flight: accept a store of 0xFF to 0x40, then assert `rst` before the next edge → no `rsp_valid`; memory [0x40] is unchanged; all outputs are at reset values; `rr_ptr` = 0 afterwards.
- Idle: no valids for 10 cycles → `mem_write_en` = 0, `rsp_valid` = 0, `rr_ptr` unchanged.
